// File: rtl/elevator_pkg.sv
// Shared types and helpers for the 4-floor elevator car controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] calls_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } car_state_t;

    // True when any call is latched for a floor strictly above 'floor'.
    function automatic logic any_above(input calls_t pending, input floor_t floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor)) begin
                r = r | pending[i];
            end
        end
        return r;
    endfunction

    // True when any call is latched for a floor strictly below 'floor'.
    function automatic logic any_below(input calls_t pending, input floor_t floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(floor)) begin
                r = r | pending[i];
            end
        end
        return r;
    endfunction

    // One-hot mask selecting the call bit of a floor.
    function automatic calls_t floor_mask(input floor_t floor);
        calls_t m;
        m        = '0;
        m[floor] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/elevator_car_ctrl_dir_arb.sv
// SCAN direction arbiter: decides serve / go up / go down for a given floor.
// Purely combinational so the priority policy can be exercised on its own.
module elevator_dir_arb
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pend_nxt,
    input  logic [1:0]            floor,
    input  logic                  dir_up,
    output logic                  go_up,
    output logic                  go_down,
    output logic                  serve_here
);

    logic above;
    logic below;

    // Serving the current floor wins; otherwise keep the current sweep
    // direction, and reverse only when nothing is left ahead.
    always_comb begin
        above      = any_above(pend_nxt, floor);
        below      = any_below(pend_nxt, floor);
        serve_here = pend_nxt[floor];
        go_up      = 1'b0;
        go_down    = 1'b0;
        if (!serve_here) begin
            if (dir_up) begin
                go_up   = above;
                go_down = !above && below;
            end else begin
                go_down = below;
                go_up   = !below && above;
            end
        end
    end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Car position and door controller for a 4-floor elevator.
// Latches calls, moves one floor per TRAVEL_CYCLES using SCAN ordering and
// opens the door for DOOR_CYCLES at every served floor. floor_sel and door
// feed the floor/door display directly.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    output logic [1:0]            floor_sel,
    output logic                  door,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES);

    localparam logic [TIMER_W-1:0] TRAVEL_RELOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_RELOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE     = TIMER_W'(1);

    car_state_t           state;
    car_state_t           state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    floor_t               floor_nxt;
    calls_t               pending_nxt;
    logic                 dir_up;
    logic                 dir_nxt;

    calls_t               pend_nxt;
    logic                 moving;
    logic                 arrive;
    floor_t               arb_floor;
    logic                 go_up;
    logic                 go_down;
    logic                 serve_here;
    logic                 continue_move;
    logic                 dwell_reload;

    // New calls join the latched set in the same cycle they are seen.
    assign pend_nxt = pending | call_req;

    // While moving, the arbiter looks at the floor being arrived at so the
    // serve/continue/stop decision is taken on the same edge as the step.
    always_comb begin
        moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
        arrive    = moving && (timer == '0);
        arb_floor = floor_sel;
        if (arrive) begin
            arb_floor = (state == MOVE_UP) ? floor_t'(floor_sel + 2'd1)
                                           : floor_t'(floor_sel - 2'd1);
        end
    end

    elevator_dir_arb u_dir_arb (
        .pend_nxt   (pend_nxt),
        .floor      (arb_floor),
        .dir_up     (dir_up),
        .go_up      (go_up),
        .go_down    (go_down),
        .serve_here (serve_here)
    );

    // Helper terms: keep sweeping in the current direction, or extend the dwell.
    always_comb begin
        continue_move = (state == MOVE_UP) ? go_up : go_down;
        dwell_reload  = door_hold || serve_here;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (serve_here) begin
                    state_nxt = DOOR_OPEN;
                end else if (go_up) begin
                    state_nxt = MOVE_UP;
                end else if (go_down) begin
                    state_nxt = MOVE_DOWN;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (arrive) begin
                    if (serve_here) begin
                        state_nxt = DOOR_OPEN;
                    end else if (!continue_move) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (!dwell_reload && (timer == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state; door and motion are mutually exclusive.
    always_comb begin
        door        = 1'b0;
        moving_up   = 1'b0;
        moving_down = 1'b0;
        case (state)
            MOVE_UP:   moving_up   = 1'b1;
            MOVE_DOWN: moving_down = 1'b1;
            DOOR_OPEN: door        = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: timer, floor, latched calls and sweep direction.
    always_comb begin
        timer_nxt   = timer;
        floor_nxt   = floor_sel;
        pending_nxt = pend_nxt;
        dir_nxt     = dir_up;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (serve_here) begin
                    pending_nxt = pend_nxt & ~floor_mask(floor_sel);
                    timer_nxt   = DOOR_RELOAD;
                end else if (go_up) begin
                    timer_nxt = TRAVEL_RELOAD;
                    dir_nxt   = 1'b1;
                end else if (go_down) begin
                    timer_nxt = TRAVEL_RELOAD;
                    dir_nxt   = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (!arrive) begin
                    timer_nxt = timer - TIMER_ONE;
                end else begin
                    floor_nxt = arb_floor;
                    if (serve_here) begin
                        pending_nxt = pend_nxt & ~floor_mask(arb_floor);
                        timer_nxt   = DOOR_RELOAD;
                    end else if (continue_move) begin
                        timer_nxt = TRAVEL_RELOAD;
                    end else begin
                        timer_nxt = '0;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for the open floor is absorbed by the dwell, never latched.
                pending_nxt = pend_nxt & ~floor_mask(floor_sel);
                if (dwell_reload) begin
                    timer_nxt = DOOR_RELOAD;
                end else if (timer != '0) begin
                    timer_nxt = timer - TIMER_ONE;
                end else begin
                    timer_nxt = '0;
                end
            end
            default: begin
                timer_nxt = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            floor_sel <= '0;
            pending   <= '0;
            dir_up    <= 1'b1;
        end else begin
            timer     <= timer_nxt;
            floor_sel <= floor_nxt;
            pending   <= pending_nxt;
            dir_up    <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=3,
// followed by a random call stream watched by per-cycle invariants.
module tb_elevator_car_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] call_req;
    logic       door_hold;
    logic [1:0] floor_sel;
    logic       door;
    logic       moving_up;
    logic       moving_down;
    logic [3:0] pending;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    elevator_car_ctrl #(
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_req    (call_req),
        .door_hold   (door_hold),
        .floor_sel   (floor_sel),
        .door        (door),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .pending     (pending)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {floor_sel, door, moving_up, moving_down, pending}.
    task automatic chk_out(input string tag, input logic [1:0] f, input logic d,
                           input logic u, input logic dn, input logic [3:0] p);
        chk(tag, {23'd0, floor_sel, door, moving_up, moving_down, pending},
                 {23'd0, f, d, u, dn, p});
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Per-cycle invariants: door excludes motion, floor only steps by one in
    // the direction of travel, and the open floor never holds a latched call.
    logic [1:0] prev_floor;
    logic       prev_up;
    logic       prev_dn;
    logic       prev_ok = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            chk("door_excl", {31'd0, door & (moving_up | moving_down)}, 32'd0);
            if (door) chk("open_floor_unlatched", {31'd0, pending[floor_sel]}, 32'd0);
            if (prev_ok && (floor_sel != prev_floor)) begin
                if (prev_up)
                    chk("floor_step", {30'd0, floor_sel}, {30'd0, prev_floor} + 32'd1);
                else if (prev_dn)
                    chk("floor_step", {30'd0, floor_sel}, {30'd0, prev_floor} - 32'd1);
                else
                    chk("floor_step_still", {30'd0, floor_sel}, {30'd0, prev_floor});
            end
            prev_floor = floor_sel;
            prev_up    = moving_up;
            prev_dn    = moving_down;
            prev_ok    = 1'b1;
        end
    end

    initial begin
        rst_n     = 1'b0;
        call_req  = 4'b0000;
        door_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state and a quiet idle period.
        chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_out("idle_quiet", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        end

        // Call at the current floor: door opens next cycle for 3 cycles.
        call_req = 4'b0001;
        tick();
        call_req = 4'b0000;
        chk_out("here_open1", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        chk_out("here_open2", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        chk_out("here_open3", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        chk_out("here_closed", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Single trip 0 -> 3: steps at N+5, N+9, N+13.
        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        chk_out("trip_n1", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
        ticks(3);
        chk_out("trip_n4", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
        tick();
        chk_out("trip_n5", 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000);
        ticks(4);
        chk_out("trip_n9", 2'd2, 1'b0, 1'b1, 1'b0, 4'b1000);
        ticks(3);
        chk_out("trip_n12", 2'd2, 1'b0, 1'b1, 1'b0, 4'b1000);
        tick();
        chk_out("trip_n13", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000);
        ticks(3);
        chk_out("trip_closed", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Top floor boundary: call at floor 3 opens door without moving.
        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        chk_out("top_open", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000);
        ticks(3);
        chk_out("top_closed", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Start a downward trip, then reset asynchronously mid-move.
        call_req = 4'b0001;
        tick();
        call_req = 4'b0000;
        chk_out("down_start", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
        ticks(4);
        chk_out("down_floor2", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_out("after_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // SCAN: head up to 3, add calls for 0 and 2 while passing floor 1.
        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        chk_out("scan_n1", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
        ticks(4);
        chk_out("scan_n5", 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000);
        call_req = 4'b0001;
        tick();
        call_req = 4'b0100;
        tick();
        call_req = 4'b0000;
        chk_out("scan_n7", 2'd1, 1'b0, 1'b1, 1'b0, 4'b1101);
        ticks(2);
        chk_out("scan_serve2", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);

        // Door hold at floor 2 for 10 cycles, then a repeated floor-2 call.
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_out("hold_open", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
            tick();
        end
        door_hold = 1'b0;
        chk_out("hold_rel1", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        tick();
        chk_out("hold_rel2", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        call_req = 4'b0100;
        tick();
        call_req = 4'b0000;
        chk_out("recall_open1", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        tick();
        chk_out("recall_open2", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        tick();
        chk_out("recall_open3", 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        tick();
        chk_out("recall_closed", 2'd2, 1'b0, 1'b0, 1'b0, 4'b1001);

        // Continue the sweep to floor 3, then reverse to floor 0.
        tick();
        chk_out("scan_up3", 2'd2, 1'b0, 1'b1, 1'b0, 4'b1001);
        ticks(4);
        chk_out("scan_serve3", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
        ticks(3);
        chk_out("scan_idle3", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
        tick();
        chk_out("scan_down", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
        ticks(8);
        chk_out("scan_pass1", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0001);
        ticks(4);
        chk_out("scan_serve0", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Random call stream; invariants are checked every cycle.
        for (int i = 0; i < 10000; i++) begin
            call_req  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            door_hold = ($urandom_range(0, 15) == 0);
            tick();
        end
        call_req  = 4'b0000;
        door_hold = 1'b0;
        ticks(100);
        chk("drain_quiet", {25'd0, door, moving_up, moving_down, pending}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
